// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - direct-mapped BTB with 2-bit counters and EX-stage miss detection
// Optional macro BPU_STATS_EN adds branch_cnt/miss_cnt statistics outputs.
module branch_predict_unit #(
  parameter int         IDX_W    = 6,
  parameter logic [1:0] CNT_INIT = 2'b10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_if,
  output logic        predict_taken_if,
  output logic [31:0] predict_target_if,
  input  logic        branch_ex,
  input  logic        taken_ex,
  input  logic [31:0] pc4_ex,
  input  logic [31:0] target_ex,
  input  logic        predict_taken_ex,
  output logic        miss_prediction,
  output logic [31:0] redirect_pc
`ifdef BPU_STATS_EN
  ,
  output logic [31:0] branch_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  logic             valid_q [N];
  logic [TAG_W-1:0] tag_q   [N];
  logic [31:0]      tgt_q   [N];
  logic [1:0]       cnt_q   [N];

  logic [31:0]      pc_ex;
  logic [IDX_W-1:0] idx_if, idx_ex;
  logic [TAG_W-1:0] tag_if, tag_ex;
  logic             hit_if, tag_eq_ex, hit_ex;
  logic [1:0]       cnt_next;
  logic             unused_bits;

  assign pc_ex       = pc4_ex - 32'd4;
  assign idx_if      = pc_if[IDX_W+1:2];
  assign tag_if      = pc_if[31:IDX_W+2];
  assign idx_ex      = pc_ex[IDX_W+1:2];
  assign tag_ex      = pc_ex[31:IDX_W+2];
  assign unused_bits = ^{pc_if[1:0], pc_ex[1:0]};

  assign hit_if    = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
  assign tag_eq_ex = (tag_q[idx_ex] == tag_ex);
  assign hit_ex    = valid_q[idx_ex] && tag_eq_ex;

  // Fetch reads the array directly, so a same-cycle EX update is not visible yet.
  assign predict_taken_if  = rst_n && hit_if && cnt_q[idx_if][1];
  assign predict_target_if = (rst_n && hit_if) ? tgt_q[idx_if] : 32'd0;

  assign miss_prediction = rst_n &&
                           ((branch_ex && (taken_ex != predict_taken_ex)) ||
                            (!branch_ex && predict_taken_ex));

  always_comb begin
    redirect_pc = 32'd0;
    if (miss_prediction)
      redirect_pc = taken_ex ? target_ex : pc4_ex;
  end

  always_comb begin
    cnt_next = cnt_q[idx_ex];
    if (taken_ex) begin
      if (cnt_q[idx_ex] != 2'b11) cnt_next = cnt_q[idx_ex] + 2'd1;
    end else begin
      if (cnt_q[idx_ex] != 2'b00) cnt_next = cnt_q[idx_ex] - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= 32'd0;
        cnt_q[i]   <= 2'b01;
      end
    end else if (branch_ex) begin
      if (hit_ex) begin
        cnt_q[idx_ex] <= cnt_next;
        tgt_q[idx_ex] <= target_ex;
      end else if (taken_ex) begin
        valid_q[idx_ex] <= 1'b1;
        tag_q[idx_ex]   <= tag_ex;
        tgt_q[idx_ex]   <= target_ex;
        cnt_q[idx_ex]   <= CNT_INIT;
      end
    end else if (predict_taken_ex && tag_eq_ex) begin
      // A non-branch predicted taken means the entry is stale.
      valid_q[idx_ex] <= 1'b0;
    end
  end

`ifdef BPU_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt <= 32'd0;
      miss_cnt   <= 32'd0;
    end else begin
      if (branch_ex)       branch_cnt <= branch_cnt + 32'd1;
      if (miss_prediction) miss_cnt   <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - directed scoreboard bench for branch_predict_unit
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_if;
  logic        predict_taken_if;
  logic [31:0] predict_target_if;
  logic        branch_ex;
  logic        taken_ex;
  logic [31:0] pc4_ex;
  logic [31:0] target_ex;
  logic        predict_taken_ex;
  logic        miss_prediction;
  logic [31:0] redirect_pc;
`ifdef BPU_STATS_EN
  logic [31:0] branch_cnt;
  logic [31:0] miss_cnt;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pc_if             (pc_if),
    .predict_taken_if  (predict_taken_if),
    .predict_target_if (predict_target_if),
    .branch_ex         (branch_ex),
    .taken_ex          (taken_ex),
    .pc4_ex            (pc4_ex),
    .target_ex         (target_ex),
    .predict_taken_ex  (predict_taken_ex),
    .miss_prediction   (miss_prediction),
    .redirect_pc       (redirect_pc)
`ifdef BPU_STATS_EN
    ,
    .branch_cnt        (branch_cnt),
    .miss_cnt          (miss_cnt)
`endif
  );

  task automatic drive(input logic br, input logic tk, input logic pr,
                       input logic [31:0] pc4, input logic [31:0] tgt,
                       input logic [31:0] pcf);
    branch_ex        = br;
    taken_ex         = tk;
    predict_taken_ex = pr;
    pc4_ex           = pc4;
    target_ex        = tgt;
    pc_if            = pcf;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic expect4(input string tag, input logic pt, input logic [31:0] ptgt,
                         input logic ms, input logic [31:0] rd);
    push({tag, ".pt"},   {31'd0, pt});
    push({tag, ".ptgt"}, ptgt);
    push({tag, ".miss"}, {31'd0, ms});
    push({tag, ".redir"}, rd);
  endtask

  task automatic cmp(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_empty observed=%h required=expectation", obs);
    end else begin
      e = sb.pop_front();
      tests++;
      assert (obs === e.val)
      else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic check4();
    #1;
    cmp({31'd0, predict_taken_if});
    cmp(predict_target_if);
    cmp({31'd0, miss_prediction});
    cmp(redirect_pc);
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lookup(input string tag, input logic [31:0] pcf,
                        input logic pt, input logic [31:0] ptgt);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, pcf);
    expect4(tag, pt, ptgt, 1'b0, 32'd0);
    check4();
  endtask

  initial begin
    // Reset held while an allocating branch is presented: outputs forced to zero.
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 32'h44, 32'h80, 32'h40);
    @(negedge clk);
    expect4("in_reset", 1'b0, 32'd0, 1'b0, 32'd0);
    check4();
    cycle();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h40);
    rst_n = 1'b1;
    cycle();

`ifdef BPU_STATS_EN
    push("stats_rst.branch", 32'd0); cmp(branch_cnt);
    push("stats_rst.miss",   32'd0); cmp(miss_cnt);
`endif

    lookup("post_reset", 32'h40, 1'b0, 32'd0);

    // Flushed bubble with a stray taken_ex must stay silent.
    drive(1'b0, 1'b1, 1'b0, 32'h44, 32'h80, 32'h40);
    expect4("bubble", 1'b0, 32'd0, 1'b0, 32'd0);
    check4();
    cycle();

    // Taken branch not in the BTB: miss + allocate; same-cycle lookup sees old state.
    drive(1'b1, 1'b1, 1'b0, 32'h44, 32'h80, 32'h40);
    expect4("alloc", 1'b0, 32'd0, 1'b1, 32'h80);
    check4();
    cycle();
    lookup("alloc_next", 32'h40, 1'b1, 32'h80);

`ifdef BPU_STATS_EN
    push("stats_seq.branch", 32'd1); cmp(branch_cnt);
    push("stats_seq.miss",   32'd1); cmp(miss_cnt);
`endif

    // Predicted taken, resolved not taken: counter 10 -> 01.
    drive(1'b1, 1'b0, 1'b1, 32'h44, 32'h80, 32'h40);
    expect4("not_taken", 1'b1, 32'h80, 1'b1, 32'h44);
    check4();
    cycle();
    lookup("weak_nt", 32'h40, 1'b0, 32'h80);

    // Four taken resolutions saturate at 11; last one retargets to 0xC0.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'h44, (i == 3) ? 32'hC0 : 32'h80, 32'h0);
      expect4($sformatf("taken%0d", i), 1'b0, 32'd0, 1'b0, 32'd0);
      check4();
      cycle();
    end
    lookup("saturated", 32'h40, 1'b1, 32'hC0);

    drive(1'b1, 1'b0, 1'b1, 32'h44, 32'hC0, 32'h0);
    expect4("sat_nt", 1'b0, 32'd0, 1'b1, 32'h44);
    check4();
    cycle();
    lookup("after_sat_nt", 32'h40, 1'b1, 32'hC0);

    // Not-taken branch missing the BTB must not allocate.
    drive(1'b1, 1'b0, 1'b0, 32'h104, 32'h200, 32'h0);
    expect4("nt_miss", 1'b0, 32'd0, 1'b0, 32'd0);
    check4();
    cycle();
    lookup("nt_no_alloc", 32'h100, 1'b0, 32'd0);

    // Stale entry: non-branch predicted taken invalidates the matching entry.
    drive(1'b0, 1'b0, 1'b1, 32'h44, 32'd0, 32'h0);
    expect4("stale", 1'b0, 32'd0, 1'b1, 32'h44);
    check4();
    cycle();
    lookup("invalidated", 32'h40, 1'b0, 32'd0);

    // Aliasing: 0x140 shares the index of 0x40 but not the tag.
    drive(1'b1, 1'b1, 1'b0, 32'h144, 32'h300, 32'h0);
    expect4("alias_alloc", 1'b0, 32'd0, 1'b1, 32'h300);
    check4();
    cycle();
    lookup("alias_hit", 32'h140, 1'b1, 32'h300);
    lookup("alias_other", 32'h40, 1'b0, 32'd0);

    // Reset pulse covering an allocating edge discards the update.
    drive(1'b1, 1'b1, 1'b0, 32'h84, 32'h400, 32'h80);
    #2 rst_n = 1'b0;
    expect4("rst_pulse", 1'b0, 32'd0, 1'b0, 32'd0);
    check4();
    cycle();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h80);
    rst_n = 1'b1;
    cycle();
    lookup("rst_discard", 32'h80, 1'b0, 32'd0);
    lookup("rst_cleared", 32'h140, 1'b0, 32'd0);

`ifdef BPU_STATS_EN
    push("stats_rst2.branch", 32'd0); cmp(branch_cnt);
    push("stats_rst2.miss",   32'd0); cmp(miss_cnt);
`endif

    if (sb.size() != 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL provide parameter IDX_W, default 6, meaning log2 of the BTB entry count (64 entries).
REQ-002 SHALL provide parameter CNT_INIT, default 2'b10, meaning the counter value written on allocation (weakly taken).
REQ-003 clk  input  1  clock; every state update occurs on the posedge.
REQ-004 rst_n  input  1  reset: asynchronous, active-low.
REQ-005 pc_if  input  32  fetch PC being looked up.
REQ-006 predict_taken_if  output  1  fetch-stage prediction; feeds Predict_Taken_IF_ID.
REQ-007 predict_target_if  output  32  predicted next PC, valid when predict_taken_if=1.
REQ-008 branch_ex  input  1  the EX-stage instruction is a conditional direct branch.
REQ-009 taken_ex  input  1  resolved branch outcome in EX.
REQ-010 pc4_ex  input  32  PC+4 of the EX instruction, from PC_ID_EX.
REQ-011 target_ex  input  32  resolved branch target.
REQ-012 predict_taken_ex  input  1  prediction carried down the pipe, from Predict_Taken_ID_EX.
REQ-013 miss_prediction  output  1  flush request; drives the Pcsrc flush of IF_ID and ID_EX.
REQ-014 redirect_pc  output  32  PC that fetch loads when miss_prediction=1.

Function
REQ-015 SHALL hold 2^IDX_W entries. Each entry holds valid, tag = PC[31:IDX_W+2], target[31:0] and a 2-bit saturating counter.
REQ-016 SHALL index with PC[IDX_W+1:2]. The EX-side PC is pc4_ex-4.
REQ-017 SHALL drive predict_taken_if combinationally as valid & tag match & counter[1]. predict_target_if SHALL be the stored target; when there is no hit it SHALL be 0.
REQ-018 SHALL compute miss_prediction combinationally as (branch_ex & (taken_ex != predict_taken_ex)) | (~branch_ex & predict_taken_ex).
REQ-019 When taken_ex=1 and a miss occurs, redirect_pc SHALL be target_ex. For every other miss it SHALL be pc4_ex. When there is no miss it SHALL be 0.
REQ-020 On a posedge with branch_ex=1 and an EX lookup hit, the counter SHALL increment if taken and decrement otherwise, saturating at 2'b11 and 2'b00. The target SHALL be rewritten with target_ex.
REQ-021 On a posedge with branch_ex=1, an EX lookup miss and taken_ex=1, the block SHALL allocate the entry: valid=1, tag, target_ex, counter=CNT_INIT. Any existing entry is overwritten.
REQ-022 A branch that misses the EX lookup and is not taken SHALL NOT allocate.
REQ-023 On a posedge with branch_ex=0 and predict_taken_ex=1 (stale entry), the entry at the EX index SHALL be invalidated if its tag matches.
REQ-024 When an IF lookup and an EX update hit the same index in one cycle, the IF lookup SHALL see the pre-update value; there is no bypass.
REQ-025 The update latency SHALL be 1 cycle: a lookup in the cycle after the update sees the new state.
REQ-026 Bubbles flushed to zero (branch_ex=0, predict_taken_ex=0) SHALL neither update state nor raise a miss.

Reset
REQ-027 While rst_n=0, all valid bits SHALL clear, all counters SHALL reset to 2'b01, and all tags and targets SHALL reset to 0.
REQ-028 While rst_n=0, miss_prediction, redirect_pc, predict_taken_if and predict_target_if SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL discard any update pending for that edge.

Configuration
REQ-030 Macro BPU_STATS_EN SHALL control statistics.
- Defined: adds outputs branch_cnt[31:0] and miss_cnt[31:0]. branch_cnt counts edges with branch_ex=1. miss_cnt counts edges with miss_prediction=1. Both wrap at 2^32-1 -> 0 and reset to 0.
- Undefined: neither port nor either counter exists.

Verification
REQ-031 After reset, pc_if=0x40 -> predict_taken_if=0, predict_target_if=0, miss_prediction=0.
REQ-032 Branch at 0x40 (pc4_ex=0x44, target_ex=0x80, taken, predict 0) -> miss=1 and redirect=0x80. Next cycle pc_if=0x40 -> predict_taken_if=1, predict_target_if=0x80.
REQ-033 Same branch with predict_taken_ex=1, taken_ex=0 -> miss=1, redirect=0x44, counter 10->01. Next lookup of 0x40 -> predict_taken_if=0.
REQ-034 Four consecutive taken resolutions -> counter saturates at 11. One not-taken -> 10, and the prediction stays taken.
REQ-035 branch_ex=0, predict_taken_ex=1, pc4_ex=0x44 -> miss=1, redirect=0x44, and the entry for 0x40 is invalidated.
REQ-036 rst_n pulsed low during an allocating cycle -> the entry stays invalid. With BPU_STATS_EN, the counts are 0 after reset and increment correctly on the REQ-032 sequence.
